// File: rtl/simd_reduce_seq.sv
// Horizontal reduction of a 64-bit SIMD vector: folds the vector in half each cycle through the shared lazy adder.
// Latency: 3 - ww RUN cycles after accept, then the result is held in DONE (ww = 11 gives the result the cycle after accept).
// Backpressure: the result holds until out_ready; in_ready is low while running, and a new request can be accepted on the retire edge.
module simd_reduce_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    input  logic [1:0]  in_ww,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic [0:63] adder_op1,
    output logic [0:63] adder_in2,
    output logic [1:0]  adder_ww,
    output logic        adder_sub,
    input  logic [0:63] adder_result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [0:63] acc;
    logic [1:0]  w_r;
    logic [5:0]  shamt;
    logic [1:0]  steps_left;
    logic        accept;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // Bit 0 is the MSB, so a numeric left shift moves the lower half up onto element 0.
    assign adder_op1 = acc;
    assign adder_in2 = acc << shamt;
    assign adder_ww  = w_r;
    assign adder_sub = 1'b0;

    always_comb begin
        out_data = '0;
        if (state == DONE) begin
            case (w_r)
                2'b00:   out_data = {56'b0, acc[0:7]};
                2'b01:   out_data = {48'b0, acc[0:15]};
                2'b10:   out_data = {32'b0, acc[0:31]};
                default: out_data = acc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            w_r        <= 2'b00;
            shamt      <= 6'd32;
            steps_left <= 2'd0;
        end else if (accept) begin
            // Covers both a fresh start in IDLE and a load on the edge that retires a DONE result.
            acc        <= in_data;
            w_r        <= in_ww;
            shamt      <= 6'd32;
            steps_left <= 2'd3 - in_ww;
            state      <= (in_ww == 2'b11) ? DONE : RUN;
        end else begin
            case (state)
                RUN: begin
                    acc        <= adder_result;
                    shamt      <= shamt >> 1;
                    steps_left <= steps_left - 2'd1;
                    if (steps_left == 2'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_reduce_seq.sv
// Bench for simd_reduce_seq: behavioural lazy adder, table vectors, corner sequences and random scoreboard run.
module tb_simd_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:63] in_data;
    logic [1:0]  in_ww;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_data;
    logic [0:63] adder_op1;
    logic [0:63] adder_in2;
    logic [1:0]  adder_ww;
    logic        adder_sub;
    logic [0:63] adder_result;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    simd_reduce_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ww(in_ww),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .adder_op1(adder_op1), .adder_in2(adder_in2), .adder_ww(adder_ww),
        .adder_sub(adder_sub), .adder_result(adder_result)
    );

    function automatic logic [63:0] lane_mask(input logic [1:0] ww);
        return (ww == 2'b11) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << ww)) - 64'd1);
    endfunction

    function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ww);
        logic [63:0] r;
        logic [63:0] m;
        int w;
        r = '0;
        m = lane_mask(ww);
        w = 8 << ww;
        for (int i = 0; i < 64; i += w) r |= (((a >> i) + (b >> i)) & m) << i;
        return r;
    endfunction

    function automatic logic [63:0] ref_sum(input logic [63:0] d, input logic [1:0] ww);
        logic [63:0] s;
        logic [63:0] m;
        int w;
        s = '0;
        m = lane_mask(ww);
        w = 8 << ww;
        for (int i = 0; i < 64; i += w) s = (s + ((d >> i) & m)) & m;
        return s;
    endfunction

    // Behavioural lazy adder with carries cut at element boundaries.
    always_comb adder_result = lane_add(adder_op1, adder_in2, adder_ww);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", out_data);
            end else begin
                chk("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic [1:0] ww, input logic [63:0] expv);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ww    = ww;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end else begin
            exp_q.push_back(expv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_ww    = 2'($urandom_range(0, 3));
    endtask

    // Called just after the accept edge; follows the fold and checks timing.
    task automatic wait_result(input logic [63:0] d, input logic [1:0] ww);
        logic [63:0] m;
        int sh;
        int edges;
        m = d;
        sh = 32;
        edges = 1;
        while (!out_valid && edges < 8) begin
            chk("ready_in_run", 64'(in_ready), 64'd0);
            chk("op1_run", adder_op1, m);
            chk("in2_shift", adder_in2, m << sh);
            m = lane_add(m, m << sh, ww);
            sh = sh >> 1;
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency_edges", 64'(edges), 64'(4 - int'(ww)));
    endtask

    typedef struct {
        logic [63:0] data;
        logic [1:0]  ww;
        logic [63:0] expv;
    } vec_t;

    vec_t tbl[6];
    logic [63:0] held;
    logic [63:0] rd;
    logic [1:0]  rw;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'h0102030405060708, 2'b00, 64'h24};
        tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 2'b00, 64'hF8};
        tbl[2] = '{64'h000100020003FFFF, 2'b01, 64'h5};
        tbl[3] = '{64'h8000000080000000, 2'b10, 64'h0};
        tbl[4] = '{64'h8000000080000000, 2'b11, 64'h8000000080000000};
        tbl[5] = '{64'h123456789ABCDEF0, 2'b10, 64'hACF13568};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ww = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_op1", adder_op1, 64'd0);
        chk("rst_in2", adder_in2, 64'd0);
        chk("rst_ww", 64'(adder_ww), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, tbl[i].ww, tbl[i].expv);
            wait_result(tbl[i].data, tbl[i].ww);
            chk("sub_tied", 64'(adder_sub), 64'd0);
        end
        @(posedge clk);
        #1;

        // Backpressure, then back-to-back accept on the retire edge.
        out_ready = 1'b0;
        send(64'h0102030405060708, 2'b00, 64'h24);
        wait_result(64'h0102030405060708, 2'b00);
        held = out_data;
        in_valid = 1'b1;
        in_data  = 64'h0001000100010001;
        in_ww    = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", out_data, held);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        send(64'h0001000100010001, 2'b01, 64'h4);
        wait_result(64'h0001000100010001, 2'b01);
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle discards the operation.
        send(64'h0102030405060708, 2'b00, 64'h24);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_data", out_data, 64'd0);
        rst_n = 1'b1;
        send(64'h1010101010101010, 2'b00, 64'h80);
        wait_result(64'h1010101010101010, 2'b00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            rd = {$urandom, $urandom};
            rw = 2'($urandom_range(0, 3));
            send(rd, rw, ref_sum(rd, rw));
            wait_result(rd, rw);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_reduce_seq.md
# simd_reduce_seq

Multi-cycle horizontal-reduction sequencer for the 64-bit SIMD datapath. It accepts one packed vector and an element width, then drives the shared sub-word lazy adder for log2(64/w) cycles, folding the vector in half each cycle. It returns the modular sum of all elements in the least-significant element position. It sits directly upstream of the lazy adder, which it feeds, and also consumes that adder's result.

## Interface
Parameters: none. Width is fixed at 64 bits, with bit 0 as the MSB and element 0 occupying bits [0:w-1].

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_data  in  [0:63]  packed vector
- in_ww  in  [1:0]  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_data  out  [0:63]  reduction sum in bits [64-w:63], all other bits 0
- adder_op1  out  [0:63]  to lazy adder op1
- adder_in2  out  [0:63]  to lazy adder in2
- adder_ww  out  [1:0]  to lazy adder ww
- adder_sub  out  1  tied 0
- adder_result  in  [0:63]  lazy adder sum, combinational from the adder_* outputs

## Operation
- Registers:
  - acc[0:63]
  - w_r[1:0]
  - shamt, taking values 32/16/8
  - steps_left[1:0]
  - state, one of IDLE, RUN, DONE
- Adder drive (combinational from registers, in every state):
  - adder_op1 = acc
  - adder_in2 = acc shifted toward bit 0 by shamt, zero-filled, i.e. {acc[shamt:63], shamt zeros}
  - adder_ww = w_r
  - adder_sub = 0
- IDLE, on accept:
  - acc ← in_data, w_r ← in_ww, shamt ← 32, steps_left ← 3 − in_ww
  - Next state is DONE if steps_left = 0 (ww = 11); otherwise RUN.
- RUN, each cycle:
  - acc ← adder_result, shamt ← shamt/2, steps_left ← steps_left − 1
  - When steps_left = 1 before the update, the next state is DONE.
- DONE:
  - out_valid = 1.
  - out_data = acc with everything except element 0 masked off, and element 0 placed in the LS w bits. For ww = 11, out_data = acc.
  - On out_ready the next state is IDLE, unless a new accept occurs in the same cycle (see below).
- in_ready = (state == IDLE) || (state == DONE && out_ready).
  - An accept while in DONE loads the new request in the same edge that retires the old result. Back-to-back operation needs no idle bubble.
- Arithmetic: each step is a per-element add at width w with carries cut at element boundaries. The result is therefore the sum of all elements mod 2^w. Overflow is silent; there is no saturation and no flag.
- The upper half of acc after each step is don't-care and never reaches out_data.
- in_data and in_ww are sampled only on accept; changing them at other times has no effect.

## Timing
- Reset (rst_n = 0 at an edge): state ← IDLE, acc ← 0, w_r ← 0, shamt ← 32, steps_left ← 0.
  - Outputs after reset: out_valid = 0, in_ready = 1, out_data = 0, adder_op1 = 0, adder_in2 = 0, adder_ww = 00.
- Reset during RUN or DONE discards the operation in flight; no result is produced.
- Latency is counted from the accept edge to the first cycle with out_valid = 1:
  - ww = 00 (byte): 3 RUN cycles, out_valid asserted after 4 edges, i.e. 3 cycles after accept
  - ww = 01: 2 RUN cycles
  - ww = 10: 1 RUN cycle
  - ww = 11: out_valid in the cycle after accept (0 RUN cycles)
- Throughput with out_ready held at 1 is one result per steps+1 cycles.
- out_valid, once asserted, holds with out_data stable until the out_ready handshake.
- in_ready is 0 throughout RUN.
- The adder path is combinational, so the full lazy-adder delay plus the acc register setup must fit in one clk period.

## Test plan
- Byte sum: in_data = 0x0102030405060708, ww = 00, out_ready = 1. Required: out_data = 0x0000000000000024; out_valid is high exactly 4 edges after accept; in_ready is low for the 3 RUN cycles.
- Byte wrap: in_data = 0xFFFFFFFFFFFFFFFF, ww = 00. Required: out_data = 0x00000000000000F8 (2040 mod 256). Halfword wrap: in_data = 0x00010002 0003FFFF, ww = 01. Required: out_data = 0x0000000000000005.
- Word and dword: in_data = 0x8000000080000000, ww = 10. Required: out_data = 0, 1 RUN cycle. Same data with ww = 11. Required: out_data = 0x8000000080000000, out_valid the cycle after accept.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 5 cycles after out_valid. Required: out_data stays stable and in_ready = 0.
  - Then raise out_ready with a second request pending. Required: the second request is accepted on the same edge, and its result follows with no idle cycle.
- Reset mid-operation: assert rst_n = 0 during the second RUN cycle of a ww = 00 reduction. Required: next cycle out_valid = 0, in_ready = 1, out_data = 0. A fresh request afterwards produces the correct result.
- Randomized check: 1000 random vectors and widths against a reference model computing the sum of elements mod 2^w. Also check each cycle that adder_in2 equals acc shifted by 32, then 16, then 8 bits.
